// File: rtl/vscale_hasti_arbiter.sv
// Two-master to one-slave HASTI (AHB-lite) arbiter with data-phase routing and loser response buffer.
// Optional per-master arbitration stall counters are enabled by defining VSCALE_HASTI_ARB_STATS_EN.

`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif
`ifndef HASTI_TRANS_IDLE
`define HASTI_TRANS_IDLE 2'd0
`endif
`ifndef HASTI_TRANS_NONSEQ
`define HASTI_TRANS_NONSEQ 2'd2
`endif
`ifndef HASTI_TRANS_SEQ
`define HASTI_TRANS_SEQ 2'd3
`endif
`ifndef HASTI_RESP_OKAY
`define HASTI_RESP_OKAY 1'b0
`endif

module vscale_hasti_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [`HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                          m0_hwrite,
  input  logic [`HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [`HASTI_BURST_WIDTH-1:0] m0_hburst,
  input  logic                          m0_hmastlock,
  input  logic [`HASTI_PROT_WIDTH-1:0]  m0_hprot,
  input  logic [`HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [`HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [`HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                          m0_hready,
  output logic [`HASTI_RESP_WIDTH-1:0]  m0_hresp,
  input  logic [`HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                          m1_hwrite,
  input  logic [`HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [`HASTI_BURST_WIDTH-1:0] m1_hburst,
  input  logic                          m1_hmastlock,
  input  logic [`HASTI_PROT_WIDTH-1:0]  m1_hprot,
  input  logic [`HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [`HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [`HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                          m1_hready,
  output logic [`HASTI_RESP_WIDTH-1:0]  m1_hresp,
  output logic [`HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                          s_hwrite,
  output logic [`HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [`HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                          s_hmastlock,
  output logic [`HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [`HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [`HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [`HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                          s_hready,
  input  logic [`HASTI_RESP_WIDTH-1:0]  s_hresp
`ifdef VSCALE_HASTI_ARB_STATS_EN
  ,
  output logic [31:0]                   stall_cnt_m0,
  output logic [31:0]                   stall_cnt_m1
`endif
);

  logic                         w_m0_req, w_m1_req;
  logic                         w_arb_valid, w_arb_id;
  logic                         w_gnt_valid, w_gnt_id;
  logic                         w_m0_won, w_m1_won;
  logic                         w_m0_lost, w_m1_lost;
  logic                         w_own0, w_own1;
  logic                         r_data_valid, r_data_owner;
  logic                         r_rr_last;
  logic                         r_buf_valid0, r_buf_valid1;
  logic [`HASTI_BUS_WIDTH-1:0]  r_buf_rdata;
  logic [`HASTI_RESP_WIDTH-1:0] r_buf_resp;

  assign w_m0_req = (m0_htrans == `HASTI_TRANS_NONSEQ) || (m0_htrans == `HASTI_TRANS_SEQ);
  assign w_m1_req = (m1_htrans == `HASTI_TRANS_NONSEQ) || (m1_htrans == `HASTI_TRANS_SEQ);

  always_comb begin
    w_arb_valid = w_m0_req || w_m1_req;
    w_arb_id    = 1'b0;
    if (w_m0_req && w_m1_req)
      w_arb_id = (FIXED_PRIORITY != 0) ? 1'b1 : ~r_rr_last;
    else if (w_m1_req)
      w_arb_id = 1'b1;
  end

  // The frozen grant during a slave stall is exactly the data-phase owner register.
  assign w_gnt_valid = s_hready ? w_arb_valid : r_data_valid;
  assign w_gnt_id    = s_hready ? w_arb_id    : r_data_owner;
  assign w_m0_won    = w_gnt_valid && !w_gnt_id;
  assign w_m1_won    = w_gnt_valid &&  w_gnt_id;
  assign w_m0_lost   = w_m0_req && !w_m0_won;
  assign w_m1_lost   = w_m1_req && !w_m1_won;
  assign w_own0      = r_data_valid && !r_data_owner;
  assign w_own1      = r_data_valid &&  r_data_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_valid <= 1'b0;
      r_data_owner <= 1'b0;
      r_rr_last    <= 1'b1;
      r_buf_valid0 <= 1'b0;
      r_buf_valid1 <= 1'b0;
      r_buf_rdata  <= '0;
      r_buf_resp   <= `HASTI_RESP_OKAY;
    end else if (s_hready) begin
      r_data_valid <= w_arb_valid;
      r_data_owner <= w_arb_id;
      if (w_m0_req && w_m1_req)
        r_rr_last <= w_arb_id;
      if (w_m0_won)
        r_buf_valid0 <= 1'b0;
      if (w_m1_won)
        r_buf_valid1 <= 1'b0;
      // A data owner that loses the next address phase saw hready=0, so keep its response.
      if (w_own0 && w_m0_lost) begin
        r_buf_valid0 <= 1'b1;
        r_buf_rdata  <= s_hrdata;
        r_buf_resp   <= s_hresp;
      end
      if (w_own1 && w_m1_lost) begin
        r_buf_valid1 <= 1'b1;
        r_buf_rdata  <= s_hrdata;
        r_buf_resp   <= s_hresp;
      end
    end
  end

  always_comb begin
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_hsize     = '0;
    s_hburst    = '0;
    s_hmastlock = 1'b0;
    s_hprot     = '0;
    s_htrans    = `HASTI_TRANS_IDLE;
    if (!reset && w_gnt_valid) begin
      if (w_gnt_id) begin
        s_haddr     = m1_haddr;
        s_hwrite    = m1_hwrite;
        s_hsize     = m1_hsize;
        s_hburst    = m1_hburst;
        s_hmastlock = m1_hmastlock;
        s_hprot     = m1_hprot;
        s_htrans    = m1_htrans;
      end else begin
        s_haddr     = m0_haddr;
        s_hwrite    = m0_hwrite;
        s_hsize     = m0_hsize;
        s_hburst    = m0_hburst;
        s_hmastlock = m0_hmastlock;
        s_hprot     = m0_hprot;
        s_htrans    = m0_htrans;
      end
    end
  end

  assign s_hwdata = r_data_owner ? m1_hwdata : m0_hwdata;

  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    m0_hrdata = '0;
    m1_hrdata = '0;
    m0_hresp  = `HASTI_RESP_OKAY;
    m1_hresp  = `HASTI_RESP_OKAY;
    if (!reset) begin
      if (w_m0_req)    m0_hready = w_m0_won ? s_hready : 1'b0;
      else if (w_own0) m0_hready = s_hready;
      if (w_m1_req)    m1_hready = w_m1_won ? s_hready : 1'b0;
      else if (w_own1) m1_hready = s_hready;
      if (r_buf_valid0) begin
        m0_hrdata = r_buf_rdata;
        m0_hresp  = r_buf_resp;
      end else if (w_own0) begin
        m0_hrdata = s_hrdata;
        m0_hresp  = s_hresp;
      end
      if (r_buf_valid1) begin
        m1_hrdata = r_buf_rdata;
        m1_hresp  = r_buf_resp;
      end else if (w_own1) begin
        m1_hrdata = s_hrdata;
        m1_hresp  = s_hresp;
      end
    end
  end

`ifdef VSCALE_HASTI_ARB_STATS_EN
  // Only arbitration losses count; cycles where the slave itself stalls are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_m0 <= '0;
      stall_cnt_m1 <= '0;
    end else if (s_hready) begin
      if (w_m0_lost && (stall_cnt_m0 != 32'hFFFF_FFFF))
        stall_cnt_m0 <= stall_cnt_m0 + 32'd1;
      if (w_m1_lost && (stall_cnt_m1 != 32'hFFFF_FFFF))
        stall_cnt_m1 <= stall_cnt_m1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed self-checking bench: one round-robin and one fixed-priority arbiter share master/slave stimulus.
// Stall counter checks are compiled in when VSCALE_HASTI_ARB_STATS_EN is defined.

module tb_vscale_hasti_arbiter;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic       OKAY   = 1'b0;
  localparam logic       ERROR  = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          failures = 0;

  logic [31:0] m0Haddr, m1Haddr, m0Hwdata, m1Hwdata;
  logic        m0Hwrite, m1Hwrite;
  logic [1:0]  m0Htrans, m1Htrans;
  logic [31:0] sHrdata;
  logic        sHready;
  logic        sHresp;

  logic [31:0] rrM0Hrdata, rrM1Hrdata, rrSHaddr, rrSHwdata;
  logic        rrM0Hready, rrM1Hready, rrM0Hresp, rrM1Hresp, rrSHwrite, rrSHmastlock;
  logic [2:0]  rrSHsize, rrSHburst;
  logic [3:0]  rrSHprot;
  logic [1:0]  rrSHtrans;
  logic [31:0] fpM0Hrdata, fpM1Hrdata, fpSHaddr, fpSHwdata;
  logic        fpM0Hready, fpM1Hready, fpM0Hresp, fpM1Hresp, fpSHwrite, fpSHmastlock;
  logic [2:0]  fpSHsize, fpSHburst;
  logic [3:0]  fpSHprot;
  logic [1:0]  fpSHtrans;
`ifdef VSCALE_HASTI_ARB_STATS_EN
  logic [31:0] rrStall0, rrStall1, fpStall0, fpStall1;
`endif

  always #5 clock = ~clock;

  vscale_hasti_arbiter #(.FIXED_PRIORITY(0)) dutRr (
    .clk(clock), .reset(reset),
    .m0_haddr(m0Haddr), .m0_hwrite(m0Hwrite), .m0_hsize(3'd2), .m0_hburst(3'd0),
    .m0_hmastlock(1'b0), .m0_hprot(4'd3), .m0_htrans(m0Htrans), .m0_hwdata(m0Hwdata),
    .m0_hrdata(rrM0Hrdata), .m0_hready(rrM0Hready), .m0_hresp(rrM0Hresp),
    .m1_haddr(m1Haddr), .m1_hwrite(m1Hwrite), .m1_hsize(3'd2), .m1_hburst(3'd0),
    .m1_hmastlock(1'b0), .m1_hprot(4'd3), .m1_htrans(m1Htrans), .m1_hwdata(m1Hwdata),
    .m1_hrdata(rrM1Hrdata), .m1_hready(rrM1Hready), .m1_hresp(rrM1Hresp),
    .s_haddr(rrSHaddr), .s_hwrite(rrSHwrite), .s_hsize(rrSHsize), .s_hburst(rrSHburst),
    .s_hmastlock(rrSHmastlock), .s_hprot(rrSHprot), .s_htrans(rrSHtrans), .s_hwdata(rrSHwdata),
    .s_hrdata(sHrdata), .s_hready(sHready), .s_hresp(sHresp)
`ifdef VSCALE_HASTI_ARB_STATS_EN
    , .stall_cnt_m0(rrStall0), .stall_cnt_m1(rrStall1)
`endif
  );

  vscale_hasti_arbiter #(.FIXED_PRIORITY(1)) dutFp (
    .clk(clock), .reset(reset),
    .m0_haddr(m0Haddr), .m0_hwrite(m0Hwrite), .m0_hsize(3'd2), .m0_hburst(3'd0),
    .m0_hmastlock(1'b0), .m0_hprot(4'd3), .m0_htrans(m0Htrans), .m0_hwdata(m0Hwdata),
    .m0_hrdata(fpM0Hrdata), .m0_hready(fpM0Hready), .m0_hresp(fpM0Hresp),
    .m1_haddr(m1Haddr), .m1_hwrite(m1Hwrite), .m1_hsize(3'd2), .m1_hburst(3'd0),
    .m1_hmastlock(1'b0), .m1_hprot(4'd3), .m1_htrans(m1Htrans), .m1_hwdata(m1Hwdata),
    .m1_hrdata(fpM1Hrdata), .m1_hready(fpM1Hready), .m1_hresp(fpM1Hresp),
    .s_haddr(fpSHaddr), .s_hwrite(fpSHwrite), .s_hsize(fpSHsize), .s_hburst(fpSHburst),
    .s_hmastlock(fpSHmastlock), .s_hprot(fpSHprot), .s_htrans(fpSHtrans), .s_hwdata(fpSHwdata),
    .s_hrdata(sHrdata), .s_hready(sHready), .s_hresp(sHresp)
`ifdef VSCALE_HASTI_ARB_STATS_EN
    , .stall_cnt_m0(fpStall0), .stall_cnt_m1(fpStall1)
`endif
  );

  // Drives both masters' address/data phase signals for the coming cycle.
  task automatic applyStimulus(input logic [1:0] t0, input logic [31:0] a0, input logic w0,
                               input logic [31:0] d0, input logic [1:0] t1, input logic [31:0] a1,
                               input logic w1, input logic [31:0] d1);
    m0Htrans = t0; m0Haddr = a0; m0Hwrite = w0; m0Hwdata = d0;
    m1Htrans = t1; m1Haddr = a1; m1Hwrite = w1; m1Hwdata = d1;
  endtask

  // Drives the shared slave response for the coming cycle.
  task automatic applySlave(input logic rdy, input logic [31:0] rdata, input logic resp);
    sHready = rdy; sHrdata = rdata; sHresp = resp;
  endtask

  // Outputs are forced to their idle values while reset is held, even with both masters requesting.
  task automatic test_reset;
    applyStimulus(NONSEQ, 32'h10, 1'b0, 32'h0, NONSEQ, 32'h20, 1'b0, 32'h0);
    applySlave(1'b1, 32'hFFFF_FFFF, OKAY);
    @(negedge clock); #1;
    checks++; if (rrSHtrans !== IDLE) begin failures++; $display("[TB] FAIL rst_htrans: got %0d want %0d", rrSHtrans, IDLE); end
    checks++; if (rrSHaddr !== 32'h0) begin failures++; $display("[TB] FAIL rst_haddr: got %h want %h", rrSHaddr, 32'h0); end
    checks++; if (rrSHwrite !== 1'b0) begin failures++; $display("[TB] FAIL rst_hwrite: got %b want 0", rrSHwrite); end
    checks++; if ({rrM0Hready, rrM1Hready} !== 2'b11) begin failures++; $display("[TB] FAIL rst_hready: got %b want 11", {rrM0Hready, rrM1Hready}); end
    checks++; if (rrM0Hrdata !== 32'h0 || rrM0Hresp !== OKAY) begin failures++; $display("[TB] FAIL rst_m0_resp: got %h/%b want 0/0", rrM0Hrdata, rrM0Hresp); end
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h0);
  endtask

  // m0 alone issues back-to-back reads; no stalls are inserted.
  task automatic test_single_master;
    @(negedge clock);
    applyStimulus(NONSEQ, 32'h100, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h0);
    applySlave(1'b1, 32'h0, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h100 || rrSHtrans !== NONSEQ) begin failures++; $display("[TB] FAIL sm_addr0: got %h/%0d want 100/2", rrSHaddr, rrSHtrans); end
    checks++; if ({rrM0Hready, rrM1Hready} !== 2'b11) begin failures++; $display("[TB] FAIL sm_hready0: got %b want 11", {rrM0Hready, rrM1Hready}); end
    @(negedge clock);
    applyStimulus(NONSEQ, 32'h104, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h0);
    applySlave(1'b1, 32'hA000_0100, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h104) begin failures++; $display("[TB] FAIL sm_addr1: got %h want 104", rrSHaddr); end
    checks++; if (rrM0Hrdata !== 32'hA000_0100 || rrM0Hready !== 1'b1) begin failures++; $display("[TB] FAIL sm_rdata1: got %h/%b want a0000100/1", rrM0Hrdata, rrM0Hready); end
    @(negedge clock);
    applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h0);
    applySlave(1'b1, 32'hA000_0104, OKAY); #1;
    checks++; if (rrM0Hrdata !== 32'hA000_0104 || rrSHtrans !== IDLE) begin failures++; $display("[TB] FAIL sm_rdata2: got %h/%0d want a0000104/0", rrM0Hrdata, rrSHtrans); end
    checks++; if (rrM1Hready !== 1'b1 || rrM1Hrdata !== 32'h0) begin failures++; $display("[TB] FAIL sm_m1_idle: got %b/%h want 1/0", rrM1Hready, rrM1Hrdata); end
  endtask

  // Fixed priority: m1 wins every contended cycle, m0 holds its address.
  task automatic test_fixed_priority;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      applyStimulus(NONSEQ, 32'h400, 1'b0, 32'h0, NONSEQ, 32'h500 + 32'(4 * i), 1'b0, 32'h0);
      applySlave(1'b1, 32'h0, OKAY); #1;
      checks++; if (fpSHaddr !== 32'h500 + 32'(4 * i)) begin failures++; $display("[TB] FAIL fp_haddr%0d: got %h want %h", i, fpSHaddr, 32'h500 + 32'(4 * i)); end
      checks++; if ({fpM0Hready, fpM1Hready} !== 2'b01) begin failures++; $display("[TB] FAIL fp_hready%0d: got %b want 01", i, {fpM0Hready, fpM1Hready}); end
    end
    @(negedge clock);
    applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h0); #1;
`ifdef VSCALE_HASTI_ARB_STATS_EN
    checks++; if (fpStall0 !== 32'd4 || fpStall1 !== 32'd0) begin failures++; $display("[TB] FAIL fp_stall_cnt: got %0d/%0d want 4/0", fpStall0, fpStall1); end
`endif
    @(negedge clock);
  endtask

  // Slave inserts three wait states into an m1 write; the grant stays frozen.
  task automatic test_wait_states;
    @(negedge clock);
    applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, NONSEQ, 32'h600, 1'b1, 32'h0);
    applySlave(1'b1, 32'h0, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h600 || rrSHwrite !== 1'b1 || rrM1Hready !== 1'b1) begin failures++; $display("[TB] FAIL ws_addr: got %h/%b/%b want 600/1/1", rrSHaddr, rrSHwrite, rrM1Hready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      applyStimulus(NONSEQ, 32'h700, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h1234_5678);
      applySlave(1'b0, 32'h0, OKAY); #1;
      checks++; if (rrSHwdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL ws_hwdata%0d: got %h want 12345678", i, rrSHwdata); end
      checks++; if ({rrM0Hready, rrM1Hready} !== 2'b00) begin failures++; $display("[TB] FAIL ws_hready%0d: got %b want 00", i, {rrM0Hready, rrM1Hready}); end
      checks++; if (rrSHtrans !== IDLE) begin failures++; $display("[TB] FAIL ws_htrans%0d: got %0d want 0", i, rrSHtrans); end
    end
    @(negedge clock);
    applySlave(1'b1, 32'h0, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h700 || rrSHtrans !== NONSEQ) begin failures++; $display("[TB] FAIL ws_release: got %h/%0d want 700/2", rrSHaddr, rrSHtrans); end
    checks++; if ({rrM0Hready, rrM1Hready} !== 2'b11 || rrSHwdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL ws_done: got %b/%h want 11/12345678", {rrM0Hready, rrM1Hready}, rrSHwdata); end
  endtask

  // Two-cycle ERROR on m0's pending read (issued at the end of the wait-state test).
  task automatic test_error;
    @(negedge clock);
    applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h0);
    applySlave(1'b0, 32'h0, ERROR); #1;
    checks++; if (rrM0Hresp !== ERROR || rrM0Hready !== 1'b0) begin failures++; $display("[TB] FAIL err_c1_m0: got %b/%b want 1/0", rrM0Hresp, rrM0Hready); end
    checks++; if (rrM1Hresp !== OKAY || rrM1Hready !== 1'b1) begin failures++; $display("[TB] FAIL err_c1_m1: got %b/%b want 0/1", rrM1Hresp, rrM1Hready); end
    @(negedge clock);
    applySlave(1'b1, 32'h0, ERROR); #1;
    checks++; if (rrM0Hresp !== ERROR || rrM0Hready !== 1'b1) begin failures++; $display("[TB] FAIL err_c2_m0: got %b/%b want 1/1", rrM0Hresp, rrM0Hready); end
    checks++; if (rrM1Hresp !== OKAY || rrM1Hready !== 1'b1) begin failures++; $display("[TB] FAIL err_c2_m1: got %b/%b want 0/1", rrM1Hresp, rrM1Hready); end
    @(negedge clock);
    applySlave(1'b1, 32'h0, OKAY);
  endtask

  // Round-robin alternation; each loser's completed read returns from the buffer next time it wins.
  task automatic test_round_robin;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(NONSEQ, 32'h200, 1'b0, 32'h0, NONSEQ, 32'h300, 1'b0, 32'h0);
    applySlave(1'b1, 32'h0, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h200 || {rrM0Hready, rrM1Hready} !== 2'b10) begin failures++; $display("[TB] FAIL rr_c0: got %h/%b want 200/10", rrSHaddr, {rrM0Hready, rrM1Hready}); end
    @(negedge clock);
    applyStimulus(NONSEQ, 32'h204, 1'b0, 32'h0, NONSEQ, 32'h300, 1'b0, 32'h0);
    applySlave(1'b1, 32'hDEAD_BEEF, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h300 || {rrM0Hready, rrM1Hready} !== 2'b01) begin failures++; $display("[TB] FAIL rr_c1: got %h/%b want 300/01", rrSHaddr, {rrM0Hready, rrM1Hready}); end
    @(negedge clock);
    applyStimulus(NONSEQ, 32'h204, 1'b0, 32'h0, NONSEQ, 32'h304, 1'b0, 32'h0);
    applySlave(1'b1, 32'h3000_0000, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h204 || {rrM0Hready, rrM1Hready} !== 2'b10) begin failures++; $display("[TB] FAIL rr_c2: got %h/%b want 204/10", rrSHaddr, {rrM0Hready, rrM1Hready}); end
    checks++; if (rrM0Hrdata !== 32'hDEAD_BEEF || rrM0Hresp !== OKAY) begin failures++; $display("[TB] FAIL rr_buf_m0: got %h/%b want deadbeef/0", rrM0Hrdata, rrM0Hresp); end
    @(negedge clock);
    applyStimulus(NONSEQ, 32'h208, 1'b0, 32'h0, NONSEQ, 32'h304, 1'b0, 32'h0);
    applySlave(1'b1, 32'h2040_0000, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h304 || {rrM0Hready, rrM1Hready} !== 2'b01) begin failures++; $display("[TB] FAIL rr_c3: got %h/%b want 304/01", rrSHaddr, {rrM0Hready, rrM1Hready}); end
    checks++; if (rrM1Hrdata !== 32'h3000_0000) begin failures++; $display("[TB] FAIL rr_buf_m1: got %h want 30000000", rrM1Hrdata); end
    @(negedge clock);
    applyStimulus(NONSEQ, 32'h208, 1'b0, 32'h0, NONSEQ, 32'h308, 1'b0, 32'h0);
    applySlave(1'b1, 32'h3040_0000, OKAY); #1;
    checks++; if (rrSHaddr !== 32'h208 || rrM0Hrdata !== 32'h2040_0000) begin failures++; $display("[TB] FAIL rr_c4: got %h/%h want 208/20400000", rrSHaddr, rrM0Hrdata); end
  endtask

  // Reset lands with m0 owning the data phase and m1 holding a buffered response.
  task automatic test_reset_mid;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(NONSEQ, 32'h20C, 1'b0, 32'h0, NONSEQ, 32'h308, 1'b0, 32'h0);
    applySlave(1'b1, 32'hFFFF_FFFF, OKAY); #1;
    checks++; if (rrSHtrans !== IDLE || {rrM0Hready, rrM1Hready} !== 2'b11) begin failures++; $display("[TB] FAIL rm_during: got %0d/%b want 0/11", rrSHtrans, {rrM0Hready, rrM1Hready}); end
    @(negedge clock);
    reset = 1'b0; #1;
    checks++; if (rrSHaddr !== 32'h20C || {rrM0Hready, rrM1Hready} !== 2'b10) begin failures++; $display("[TB] FAIL rm_first_grant: got %h/%b want 20c/10", rrSHaddr, {rrM0Hready, rrM1Hready}); end
    checks++; if (rrM1Hrdata !== 32'h0 || rrM0Hrdata !== 32'h0) begin failures++; $display("[TB] FAIL rm_flushed: got %h/%h want 0/0", rrM0Hrdata, rrM1Hrdata); end
    @(negedge clock);
    applyStimulus(IDLE, 32'h0, 1'b0, 32'h0, IDLE, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_single_master;
    test_fixed_priority;
    test_wait_states;
    test_error;
    test_round_robin;
    test_reset_mid;
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vscale_hasti_arbiter.md
Name: vscale_hasti_arbiter

Overview:
- Two-master to one-slave HASTI (AHB-lite) arbiter.
- Lets the core's imem bridge (master 0) and dmem bridge (master 1) share one memory/slave port, e.g. a unified SRAM.
- Fully pipelined: grants the address phase, routes the data phase, and buffers a losing master's completed response so neither bridge needs modification.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin between masters; 1 = master 1 (dmem) always wins contention.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high
- m0_haddr, m1_haddr  input  `HASTI_ADDR_WIDTH  master address
- m0_hwrite/hsize/hburst/hmastlock/hprot/htrans (and m1_ same)  input  1/`HASTI_SIZE_WIDTH/`HASTI_BURST_WIDTH/1/`HASTI_PROT_WIDTH/`HASTI_TRANS_WIDTH  master control
- m0_hwdata, m1_hwdata  input  `HASTI_BUS_WIDTH  master write data (data phase)
- m0_hrdata, m1_hrdata  output  `HASTI_BUS_WIDTH  read data to master
- m0_hready, m1_hready  output  1  transfer-done / stall to master
- m0_hresp, m1_hresp  output  `HASTI_RESP_WIDTH  response to master
- s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata  output  (widths as above)  slave-side bus
- s_hrdata  input  `HASTI_BUS_WIDTH  slave read data
- s_hready  input  1  slave ready
- s_hresp  input  `HASTI_RESP_WIDTH  slave response

Behaviour:
- Request: mX_req = (mX_htrans == `HASTI_TRANS_NONSEQ or SEQ).
- Grant:
  - Evaluated only in cycles with s_hready=1; held in grant_q while s_hready=0.
  - Single requester wins.
  - On contention:
    - FIXED_PRIORITY=1: master 1 wins.
    - FIXED_PRIORITY=0: the master not granted last contended cycle wins (rr_last register, reset to 1, so master 0 wins first contention).
  - Idle cycles do not update rr_last.
- Slave address bus: muxed from the granted master; s_htrans = IDLE when there is no request.
- Data phase registers:
  - data_valid and data_owner are updated when s_hready=1 to (grant exists, granted id).
  - s_hwdata is muxed from data_owner.
- mX_hready:
  - Granted master (mX_req and won): s_hready.
  - Requesting master that lost: 0 (it holds its address phase, per HASTI).
  - Otherwise: 1 if it owns no unfinished data phase, else s_hready.
- Lost-while-completing case (master X owns the data phase, s_hready=1, X also requests but loses):
  - X sees hready=0.
  - The arbiter latches s_hrdata/s_hresp into buf_rdata/buf_resp and sets buf_valid_X.
  - X keeps hwdata stable, so the slave-sampled write data is correct.
- Buffer drain:
  - When X is next granted with buf_valid_X=1, mX_hrdata/mX_hresp come from the buffer in that cycle, and buf_valid_X clears.
  - At most one buffer entry exists at a time (only the data owner can lose).
- Response routing: mX_hrdata/mX_hresp are sourced from the slave when data_owner=X and no buffer entry is pending; otherwise from the buffer or zero/OKAY.
- Error responses: s_hresp=ERROR is forwarded combinationally. Its two-cycle shape is preserved because the grant is frozen while s_hready=0.
- Reset (synchronous, dominates everything):
  - data_valid=0, buf_valid=0, rr_last=1, grant_q=none.
  - Outputs: s_htrans=IDLE, s_haddr=0, s_hwrite=0, mX_hready=1, mX_hresp=OKAY, mX_hrdata=0.
  - Reset mid-transfer drops the data phase and any buffer entry without a response.
- Latency: zero added cycles with a single active master; a lost contention costs the loser exactly one stall per contended cycle.

Optional Feature:
- Macro: VSCALE_HASTI_ARB_STATS_EN.
- Defined:
  - Adds outputs stall_cnt_m0 and stall_cnt_m1 (32-bit each).
  - Each counter increments in every cycle its master requests but is stalled by arbitration; it does not count slave wait states.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single master: m0 only, NONSEQ reads at 0x100, 0x104, zero-wait slave -> one transfer per cycle; m0_hready=1 throughout; m0_hrdata matches slave data; m1_hready=1.
- Fixed priority: FIXED_PRIORITY=1, both NONSEQ every cycle for 4 cycles -> s_haddr always m1's address; m0_hready=0 all 4 cycles; stall_cnt_m0=4 when stats are enabled.
- Round-robin with buffering: FIXED_PRIORITY=0, both issuing continuous reads -> grants alternate m0,m1,m0,m1. m0's read of 0x200 returning 0xDEADBEEF while m0 loses is delivered via the buffer on m0's next granted cycle with m0_hresp=OKAY.
- Slave wait states: s_hready=0 for 3 cycles during an m1 write of 0x12345678 -> grant frozen; s_hwdata=0x12345678 stable; m1_hready=0 for 3 cycles; m0 is not granted mid-stall.
- Error: slave returns a two-cycle ERROR to m0 -> m0_hresp=ERROR in both cycles; m0_hready=0 then 1; m1 is unaffected.
- Reset mid-operation: assert reset while an m0 data phase and buffer entry are pending -> next cycle s_htrans=IDLE, both hready=1, buffer empty, and the first post-reset contention goes to m0.
